// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states, ALU selects and sizing helpers (ALU_SEQ_EQ_EN enables CMP)
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_OR  = 4'b1110;
    localparam logic [3:0] S_XOR = 4'b0110;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int nib(input int width);
        return width / 4;
    endfunction
    function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_SEQ_EQ_EN
        return op <= OP_CMP;
`else
        return op <= OP_XOR;
`endif
    endfunction
endpackage

// File: rtl/alu_seq_opmap.sv
// alu_seq_opmap: op -> ALU select, mode, first-nibble carry-in, chaining and legality (ALU_SEQ_EQ_EN adds CMP)
module alu_seq_opmap import alu_seq_pkg::*; (
    input  logic [2:0] op,
    output logic [3:0] alu_s,
    output logic       alu_m,
    output logic       ci0_n,
    output logic       chain_en,
    output logic       legal
);
    // decode op into the ALU control set; logic ops keep ci_n high and never chain
    always_comb begin
        alu_s    = 4'b0000;
        alu_m    = 1'b1;
        ci0_n    = 1'b1;
        chain_en = 1'b0;
        legal    = op_legal(op);
        case (op)
            OP_ADD: begin alu_s = S_ADD; alu_m = 1'b0; chain_en = 1'b1; end
            OP_SUB: begin alu_s = S_SUB; alu_m = 1'b0; chain_en = 1'b1; ci0_n = 1'b0; end
            OP_AND: alu_s = S_AND;
            OP_OR:  alu_s = S_OR;
            OP_XOR: alu_s = S_XOR;
`ifdef ALU_SEQ_EQ_EN
            OP_CMP: begin alu_s = S_SUB; alu_m = 1'b0; chain_en = 1'b1; end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a WIDTH-bit op through a 4-bit 74181-style ALU one nibble per cycle (ALU_SEQ_EQ_EN enables CMP/eq)
module alu_nibble_sequencer import alu_seq_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
    output logic             eq,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_ci_n,
    input  logic [3:0]       alu_y,
    input  logic             alu_co_n,
    input  logic             alu_aeqb
);
    localparam int NIB = nib(WIDTH);
    localparam int IW  = $clog2(NIB);
    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc;
    logic [IW-1:0]    idx;
    logic             cy, run, last, accept;
    logic [3:0]       m_s;
    logic             m_m, m_ci0_n, m_chain, m_legal;
    // in IDLE the map judges the incoming op; afterwards it drives the latched op
    alu_seq_opmap u_opmap (
        .op       (state == IDLE ? op : op_q),
        .alu_s    (m_s),
        .alu_m    (m_m),
        .ci0_n    (m_ci0_n),
        .chain_en (m_chain),
        .legal    (m_legal)
    );
    // next state, handshake and ALU pin drive; pins idle outside RUN
    always_comb begin
        run      = state == RUN;
        last     = idx == IW'(NIB - 1);
        accept   = state == IDLE && start;
        busy     = run;
        done     = state == DONE;
        state_nx = state == IDLE ? (start ? (m_legal ? RUN : DONE) : IDLE) :
                   run ? (last ? DONE : RUN) : IDLE;
        alu_a    = run ? a_q[4*idx +: 4] : 4'h0;
        alu_b    = run ? b_q[4*idx +: 4] : 4'h0;
        alu_s    = run ? m_s : 4'b0000;
        alu_m    = run ? m_m : 1'b1;
        alu_ci_n = run ? ((idx == '0 || !m_chain) ? m_ci0_n : ~cy) : 1'b1;
    end
`ifdef ALU_SEQ_EQ_EN
    logic eq_acc;
    // eq folds every nibble's A=B flag and publishes it with the final result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eq     <= 1'b0;
            eq_acc <= 1'b1;
        end else if (accept) begin
            eq_acc <= 1'b1;
            if (!m_legal) eq <= 1'b0;
        end else if (run) begin
            eq_acc <= eq_acc & alu_aeqb;
            if (last) eq <= op_q == OP_CMP && eq_acc && alu_aeqb;
        end
    end
`else
    logic unused_aeqb;
    assign unused_aeqb = alu_aeqb;
    assign eq = 1'b0;
`endif
    // state, operand capture, nibble accumulation and final result publication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            cy     <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept && m_legal) begin
                op_q <= op;
                a_q  <= op_a;
                b_q  <= op_b;
                idx  <= '0;
            end else if (accept) begin
                result <= '0;
                carry  <= 1'b0;
                err    <= 1'b1;
            end
            if (run) begin
                acc[4*idx +: 4] <= alu_y;
                cy              <= ~alu_co_n;
                idx             <= idx + 1'b1;
                if (last) begin
                    result <= {alu_y, acc[WIDTH-5:0]};
                    carry  <= m_chain & ~alu_co_n;
                    err    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed checks of the nibble sequencer against a behavioural 74181-style ALU
module tb_alu_nibble_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] op_a = '0, op_b = '0;
    logic        busy, done, carry, err, eq;
    logic [15:0] result;
    logic [3:0]  alu_a, alu_b, alu_s, alu_y;
    logic        alu_m, alu_ci_n, alu_co_n, alu_aeqb;
    logic [4:0]  t;
    int          n_chk = 0, n_err = 0;

    alu_nibble_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry(carry), .err(err), .eq(eq),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_ci_n(alu_ci_n),
        .alu_y(alu_y), .alu_co_n(alu_co_n), .alu_aeqb(alu_aeqb)
    );

    always #5 clk = ~clk;

    // behavioural ALU: add, subtract (A + ~B + Cin) and the three logic functions used here
    always_comb begin
        t        = 5'd0;
        alu_y    = 4'h0;
        alu_co_n = 1'b1;
        if (!alu_m) begin
            t = alu_s == 4'b1001 ? {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, ~alu_ci_n} :
                alu_s == 4'b0110 ? {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, ~alu_ci_n} : 5'd0;
            alu_y    = t[3:0];
            alu_co_n = ~t[4];
        end else begin
            alu_y = alu_s == 4'b1011 ? alu_a & alu_b :
                    alu_s == 4'b1110 ? alu_a | alu_b :
                    alu_s == 4'b0110 ? alu_a ^ alu_b : 4'h0;
        end
        alu_aeqb = alu_y == 4'hF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] x_res, input logic x_cy, input logic x_err, input logic x_eq,
                         input int x_cyc, input logic [5:0] x_pins);
        int cyc;
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7; op_a = ~a; op_b = ~b;
        check({tag, ".pins"}, {alu_s, alu_m, alu_ci_n}, x_pins);
        check({tag, ".busy"}, busy, !x_err);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, cyc, x_cyc);
        check({tag, ".res"}, result, x_res);
        check({tag, ".carry"}, carry, x_cy);
        check({tag, ".err"}, err, x_err);
        check({tag, ".eq"}, eq, x_eq);
        check({tag, ".idle_m"}, {busy, alu_m, alu_ci_n, alu_s}, 7'b0110000);
        @(posedge clk); #1;
        check({tag, ".pulse"}, done, 1'b0);
    endtask

    initial begin
        int n_done;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ctl", {busy, done, carry, err, eq}, 5'b0);
        check("rst.res", result, 16'h0);
        check("rst.pins", {alu_a, alu_b, alu_s, alu_m, alu_ci_n}, 14'b11);
        reset = 1'b0;
        @(posedge clk); #1;
        do_op("add1", 3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 5, 6'b100101);
        do_op("add2", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 6'b100101);
        do_op("sub",  3'd1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b0, 5, 6'b011000);
        do_op("xor",  3'd4, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 5, 6'b011011);
        do_op("and",  3'd2, 16'hA5A5, 16'hFFFF, 16'hA5A5, 1'b0, 1'b0, 1'b0, 5, 6'b101111);
        do_op("or",   3'd3, 16'hA5A5, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 5, 6'b111011);
        repeat (3) @(posedge clk);
        #1;
        check("hold.res", result, 16'hFFFF);
        do_op("ill7", 3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 6'b000011);
`ifdef ALU_SEQ_EQ_EN
        do_op("cmpeq", 3'd5, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b1, 5, 6'b011001);
        do_op("cmpne", 3'd5, 16'h1234, 16'h1235, 16'hFFFE, 1'b0, 1'b0, 1'b0, 5, 6'b011001);
`else
        do_op("ill5", 3'd5, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 6'b000011);
`endif
        op = 3'd0; op_a = 16'h0001; op_b = 16'h0002; start = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("hold.ndone", n_done, 1);
        check("hold.sum", result, 16'h0003);
        op = 3'd0; op_a = 16'h0011; op_b = 16'h0022; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort", {busy, done, result}, 18'h0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort.idle", {busy, done}, 2'b00);
        do_op("add3", 3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 5, 6'b100101);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
